cpu_mul_sequencer: RTL

- Multi-cycle iterative multiply controller that executes `ISA_MUL_OP` for the decode/execute pipeline.
- Decode issues an R-type MUL here instead of to the ALU. The block latches operands and destination id, then runs a shift-add sequence.
- While the sequence runs it drives a stall request toward the hazard-detection unit.
- When finished it holds the low WIDTH bits of the product and the destination register id for writeback until they are acknowledged.

---
 rtl/cpu_mul_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cpu_mul_sequencer.sv
// Iterative shift-add multiplier for the MUL instruction: latches operands, retires
// BITS_PER_CYCLE multiplier bits per cycle, holds result until acked. Option: CPU_MUL_EARLY_EXIT_EN.
module cpu_mul_sequencer #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned REG_ID_W       = 5,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    src_a,
    input  logic [WIDTH-1:0]    src_b,
    input  logic [REG_ID_W-1:0] dst,
    input  logic                flush,
    output logic                stall,
    output logic                busy,
    output logic                result_valid,
    output logic [WIDTH-1:0]    result,
    output logic [REG_ID_W-1:0] result_dst,
    input  logic                result_ack
);

    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [REG_ID_W-1:0] result_dst_q, result_dst_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    logic [WIDTH-1:0] digit_ext;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] mplier_shift;
    logic [WIDTH-1:0] mcand_shift;
    logic             early_exit;
    logic             last_step;

    // Product truncation to WIDTH bits is the intended modular arithmetic.
    assign digit_ext    = WIDTH'(mplier_q[BITS_PER_CYCLE-1:0]);
    assign partial      = mcand_q * digit_ext;
    assign acc_sum      = acc_q + partial;
    assign mplier_shift = mplier_q >> BITS_PER_CYCLE;
    assign mcand_shift  = mcand_q << BITS_PER_CYCLE;

`ifdef CPU_MUL_EARLY_EXIT_EN
    assign early_exit = (mplier_shift == '0);
`else
    assign early_exit = 1'b0;
`endif

    assign last_step = (cnt_q == LAST_STEP) || early_exit;

    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        result_dst_d = result_dst_q;
        valid_d      = valid_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    mcand_d      = src_a;
                    mplier_d     = src_b;
                    acc_d        = '0;
                    cnt_d        = '0;
                    result_dst_d = dst;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_shift;
                    mplier_d = mplier_shift;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        result_d = acc_sum;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || result_ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            result_dst_q <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            result_dst_q <= result_dst_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
        end
    end

    // Stall also covers the accept cycle so the instruction behind the MUL holds.
    assign stall = (state_q == RUN)
                || ((state_q == DONE) && !result_ack)
                || ((state_q == IDLE) && start);

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign result_dst   = result_dst_q;

endmodule
